// File: rtl/tpu_result_serializer_if.sv
// -----------------------------------------------------------------------------
// tpu_result_serializer_if
// Bundles the result handshake and serial output of the tinytpu result
// serializer.
//   res_data    N*N*ACC_W  result matrix, element k at [k*ACC_W +: ACC_W]
//   res_valid   1          res_data valid from the systolic array
//   res_ready   1          serializer can accept a frame
//   tx_en       1          bit-rate enable for the serial stream
//   data_out_z  1          serial result bit
//   tx_ready    1          data_out_z carries a frame bit this cycle
//   frame_done  1          one-cycle pulse after the last bit of a frame
// Modports: slave = serializer side, master = array/tester side.
// -----------------------------------------------------------------------------
interface tpu_result_serializer_if #(
  parameter int D_W   = 8,
  parameter int N     = 2,
  parameter int ACC_W = 2 * D_W
);
  localparam int TOTAL = N * N * ACC_W;

  logic [TOTAL-1:0] res_data;
  logic             res_valid;
  logic             res_ready;
  logic             tx_en;
  logic             data_out_z;
  logic             tx_ready;
  logic             frame_done;

  modport slave (
    input  res_data, res_valid, tx_en,
    output res_ready, data_out_z, tx_ready, frame_done
  );

  modport master (
    output res_data, res_valid, tx_en,
    input  res_ready, data_out_z, tx_ready, frame_done
  );
endinterface

// File: rtl/tpu_result_serializer.sv
// -----------------------------------------------------------------------------
// tpu_result_serializer
// Output stage of the tinytpu datapath. Captures one N x N result matrix in
// parallel and shifts it out one bit per tx_en cycle: element 0 first, then
// ascending k, each element MSB first. tx_ready frames every valid bit and
// frame_done pulses for one cycle after the last bit.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset (discards any frame in flight)
//   bus  tpu_result_serializer_if.slave (res_data/res_valid/res_ready,
//        tx_en, data_out_z, tx_ready, frame_done)
// All outputs decode from registers only; no input-to-output combinational
// path exists.
// -----------------------------------------------------------------------------
module tpu_result_serializer #(
  parameter int D_W   = 8,
  parameter int N     = 2,
  parameter int ACC_W = 2 * D_W
) (
  input  logic                          clk,
  input  logic                          rst,
  tpu_result_serializer_if.slave        bus
);
  localparam int TOTAL = N * N * ACC_W;
  localparam int CNT_W = $clog2(TOTAL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TOTAL-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reorder the matrix so the shift register's MSB is always the next wire
  // bit: element 0 lands in the top ACC_W bits, already MSB first, so a plain
  // left shift walks the frame in transmission order.
  function automatic logic [TOTAL-1:0] to_wire_order(input logic [TOTAL-1:0] m);
    logic [TOTAL-1:0] w;
    w = '0;
    for (int k = 0; k < N * N; k++) begin
      w[(N*N-1-k)*ACC_W +: ACC_W] = m[k*ACC_W +: ACC_W];
    end
    return w;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.res_valid) begin
          sr_d    = to_wire_order(bus.res_data);
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.tx_en) begin
          sr_d = {sr_q[TOTAL-2:0], 1'b0};
          if (cnt_q == LAST) begin
            // Frame complete; the counter is parked at zero rather than
            // allowed to wrap.
            cnt_d   = '0;
            state_d = GAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      GAP: begin
        // Single-cycle separator; res_valid seen here is deliberately
        // ignored so a new frame is only taken from IDLE.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    bus.res_ready  = 1'b0;
    bus.tx_ready   = 1'b0;
    bus.data_out_z = 1'b0;
    bus.frame_done = 1'b0;
    unique case (state_q)
      IDLE:  bus.res_ready = 1'b1;
      SHIFT: begin
        bus.tx_ready   = 1'b1;
        bus.data_out_z = sr_q[TOTAL-1];
      end
      GAP:   bus.frame_done = 1'b1;
      default: bus.res_ready = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_tpu_result_serializer.sv
module tb_tpu_result_serializer;
  localparam int ACC_W = 16;
  localparam int NN    = 4;
  localparam int TOTAL = NN * ACC_W;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  tpu_result_serializer_if #(.D_W(8), .N(2)) bus ();

  tpu_result_serializer #(.D_W(8), .N(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        vld;
    logic        en;
    logic [63:0] data;
    logic [3:0]  exp;   // {res_ready, tx_ready, data_out_z, frame_done}
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.res_ready, bus.tx_ready, bus.data_out_z, bus.frame_done};
  endfunction

  // Wire bit i of a frame: element i/ACC_W, MSB first within the element.
  function automatic logic exp_bit(input logic [63:0] f, input int i);
    int k;
    int b;
    k = i / ACC_W;
    b = (ACC_W - 1) - (i % ACC_W);
    return f[k*ACC_W + b];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic start_frame(input logic [63:0] f);
    int w;
    w = 0;
    while (!bus.res_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 64'(bus.res_ready), 64'd1);
    bus.res_valid = 1'b1;
    bus.res_data  = f;
    @(negedge clk);
    bus.res_valid = 1'b0;
    bus.res_data  = rnd64();
    chk("capture", 64'(bus.tx_ready), 64'd1);
  endtask

  // Called in the first bit cycle (capture edge + 1). Drives tx_en, observes
  // the stream until frame_done and scores it against the frame's wire order.
  // Returns in the frame_done cycle.
  task automatic collect(input logic [63:0] f, input int mode, input bit poke,
                         input bit b2b, input logic [63:0] f_next, input string tag);
    int          idx, mism, bad, txr, done_c;
    logic [63:0] got, expw;
    logic        en;
    idx = 0; mism = 0; bad = 0; txr = 0; done_c = 0;
    got = '0; expw = '0;
    for (int i = 0; i < TOTAL; i++) expw = {expw[62:0], exp_bit(f, i)};
    for (int c = 1; c <= 400; c++) begin
      if (bus.frame_done) begin
        done_c = c;
        chk({tag, "_gap_outs"}, 64'({bus.res_ready, bus.tx_ready, bus.data_out_z}), 64'd0);
        if (poke) begin
          bus.res_valid = 1'b1;
          bus.res_data  = rnd64();
        end
        break;
      end
      if (bus.tx_ready) begin
        txr++;
        if (idx >= TOTAL || bus.data_out_z !== exp_bit(f, idx)) mism++;
      end else begin
        bad++;
      end
      case (mode)
        0:       en = 1'b1;
        1:       en = (c % 2 == 0);
        default: en = 1'($urandom_range(0, 1));
      endcase
      if (bus.tx_ready && en) begin
        got = {got[62:0], bus.data_out_z};
        idx++;
      end
      bus.tx_en = en;
      if (b2b && c == 10) bus.res_data = f_next;
      if (poke && c == 20) begin
        bus.res_valid = 1'b1;
        bus.res_data  = rnd64();
      end
      if (poke && c == 21) bus.res_valid = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, 64'(done_c != 0), 64'd1);
    chk({tag, "_bits"}, 64'(idx), 64'(TOTAL));
    chk({tag, "_bit_mism"}, 64'(mism), 64'd0);
    chk({tag, "_txr_drop"}, 64'(bad), 64'd0);
    chk({tag, "_stream"}, got, expw);
    chk({tag, "_done_time"}, 64'(done_c), 64'(txr + 1));
    if (mode == 0) chk({tag, "_txr_cycles"}, 64'(txr), 64'd64);
    if (mode == 1) chk({tag, "_txr_cycles"}, 64'(txr), 64'd128);
  endtask

  // Called in the frame_done cycle: checks the return to IDLE.
  task automatic post_gap(input bit poke, input string tag);
    @(negedge clk);
    chk({tag, "_idle_after_gap"}, 64'(outs()), 64'(4'b1000));
    if (poke) begin
      bus.res_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_no_capture_in_gap"}, 64'(outs()), 64'(4'b1000));
    end
  endtask

  localparam logic [63:0] F0 = 64'h8001_00FF_1234_ABCD;

  initial begin
    logic [63:0] fa, fb;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    bus.tx_en     = 1'b0;

    // First wire bits of F0 (element 0 = 0xABCD): 1,0,1,0,1,...
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 64'h0, 4'b1000};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 64'h0, 4'b1000};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, F0,    4'b0110};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 64'h0, 4'b0100};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 64'h0, 4'b0100};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0110};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 64'h0, 4'b0100};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 64'h0, 4'b0110};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, F0,    4'b1000};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 64'h0, 4'b1000};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 64'h0, 4'b1000};

    for (int i = 0; i < 11; i++) begin
      rst           = tbl[i].rst;
      bus.res_valid = tbl[i].vld;
      bus.tx_en     = tbl[i].en;
      bus.res_data  = tbl[i].data;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(tbl[i].exp));
    end
    bus.res_valid = 1'b0;

    // Idle stays idle for a while with no frame_done
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_hold", 64'(outs()), 64'(4'b1000));
    end

    // Single frame, continuous enable, hand-derived wire order
    begin
      logic [63:0] got;
      got = '0;
      start_frame(F0);
      for (int i = 0; i < TOTAL; i++) begin
        bus.tx_en = 1'b1;
        got = {got[62:0], bus.data_out_z};
        @(negedge clk);
      end
      chk("f0_wire_order", got, 64'hABCD_1234_00FF_8001);
      chk("f0_done_T65", 64'(outs()), 64'(4'b0001));
      @(negedge clk);
      chk("f0_ready_T66", 64'(outs()), 64'(4'b1000));
    end

    // Same frame through the scoreboard, continuous then throttled
    start_frame(F0);
    collect(F0, 0, 1'b0, 1'b0, 64'h0, "cont");
    post_gap(1'b0, "cont");
    start_frame(F0);
    collect(F0, 1, 1'b0, 1'b0, 64'h0, "thr");
    post_gap(1'b0, "thr");

    // Ignored valid during SHIFT and GAP
    start_frame(F0);
    collect(F0, 0, 1'b1, 1'b0, 64'h0, "poke");
    post_gap(1'b1, "poke");

    // Back-to-back with res_valid held high
    fa = 64'h0123_4567_89AB_CDEF;
    fb = 64'hF0E1_D2C3_B4A5_9687;
    while (!bus.res_ready) @(negedge clk);
    bus.tx_en     = 1'b1;
    bus.res_valid = 1'b1;
    bus.res_data  = fa;
    @(negedge clk);
    collect(fa, 0, 1'b0, 1'b1, fb, "b2b1");
    @(negedge clk);
    chk("b2b_idle_T66", 64'(outs()), 64'(4'b1000));
    @(negedge clk);
    chk("b2b_capture_T66", 64'(bus.tx_ready), 64'd1);
    bus.res_valid = 1'b0;
    bus.res_data  = rnd64();
    collect(fb, 0, 1'b0, 1'b0, 64'h0, "b2b2");
    post_gap(1'b0, "b2b2");

    // Reset mid-frame after 20 bits
    start_frame(F0);
    for (int i = 0; i < 20; i++) begin
      bus.tx_en = 1'b1;
      @(negedge clk);
    end
    chk("pre_rst_shift", 64'(bus.tx_ready), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", 64'(outs()), 64'(4'b1000));
    bus.res_valid = 1'b1;
    bus.res_data  = rnd64();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold", 64'(outs()), 64'(4'b1000));
    end
    rst = 1'b0;
    bus.res_valid = 1'b0;
    @(negedge clk);
    chk("rst_release_idle", 64'(outs()), 64'(4'b1000));
    fa = 64'h5A5A_0F0F_C3C3_9999;
    start_frame(fa);
    collect(fa, 0, 1'b0, 1'b0, 64'h0, "after_rst");
    post_gap(1'b0, "after_rst");

    // Randomized frames with random enable
    for (int n = 0; n < 6; n++) begin
      fa = rnd64();
      start_frame(fa);
      collect(fa, 2, 1'(n % 2), 1'b0, 64'h0, $sformatf("rnd%0d", n));
      post_gap(1'(n % 2), $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
